// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks the register file read port over every register and streams
// each captured byte with its address. Define REGFILE_DUMP_CSUM_EN for a trailing XOR beat.
module regfile_dump_reader #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_rf_read_addr,
    input  logic [DATA_W-1:0] i_rf_read_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic              o_out_last
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CSUM_EN
    typedef enum logic [2:0] {StIdle, StFetch, StSend, StCsum, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;
`endif

    state_e            r_state, w_state_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [DATA_W-1:0] r_data, w_data_next;
`ifdef REGFILE_DUMP_CSUM_EN
    logic [DATA_W-1:0] r_csum, w_csum_next;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_data  <= '0;
`ifdef REGFILE_DUMP_CSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
`ifdef REGFILE_DUMP_CSUM_EN
            r_csum  <= w_csum_next;
`endif
        end
    end

    // Outputs are muxed off outside SEND/CSUM so the stream stays quiet when idle.
    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_data_next    = r_data;
`ifdef REGFILE_DUMP_CSUM_EN
        w_csum_next    = r_csum;
`endif
        o_busy         = (r_state != StIdle);
        o_done         = 1'b0;
        o_rf_read_addr = '0;
        o_out_valid    = 1'b0;
        o_out_data     = '0;
        o_out_addr     = '0;
        o_out_last     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_addr_next  = '0;
`ifdef REGFILE_DUMP_CSUM_EN
                    w_csum_next  = '0;
`endif
                    w_state_next = StFetch;
                end
            end
            StFetch: begin
                o_rf_read_addr = r_addr;
                w_data_next    = i_rf_read_data;
`ifdef REGFILE_DUMP_CSUM_EN
                w_csum_next    = r_csum ^ i_rf_read_data;
`endif
                w_state_next   = StSend;
            end
            StSend: begin
                o_rf_read_addr = r_addr;
                o_out_valid    = 1'b1;
                o_out_data     = r_data;
                o_out_addr     = r_addr;
`ifndef REGFILE_DUMP_CSUM_EN
                o_out_last     = (r_addr == LastAddr);
`endif
                if (i_out_ready) begin
                    if (r_addr == LastAddr) begin
`ifdef REGFILE_DUMP_CSUM_EN
                        w_state_next = StCsum;
`else
                        w_state_next = StDone;
`endif
                    end else begin
                        w_addr_next  = r_addr + 1'b1;
                        w_state_next = StFetch;
                    end
                end
            end
`ifdef REGFILE_DUMP_CSUM_EN
            StCsum: begin
                o_out_valid = 1'b1;
                o_out_data  = r_csum;
                o_out_last  = 1'b1;
                if (i_out_ready) begin
                    w_state_next = StDone;
                end
            end
`endif
            StDone: begin
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: register-file model plus a beat scoreboard.
// Expectations follow REGFILE_DUMP_CSUM_EN when it is defined.
module tb_regfile_dump_reader;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned NR = 16;
`ifdef REGFILE_DUMP_CSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    typedef struct packed {
        logic          last;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;

    logic [DW-1:0] rf [NR];
    beat_t         sb [$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int busy_low  = -1;

    always #5 clk = ~clk;

    assign rf_data = rf[rf_addr];

    regfile_dump_reader #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .NUM_REGS(NR)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .o_busy        (busy),
        .o_done        (done),
        .o_rf_read_addr(rf_addr),
        .i_rf_read_data(rf_data),
        .o_out_valid   (valid),
        .i_out_ready   (ready),
        .o_out_data    (out_data),
        .o_out_addr    (out_addr),
        .o_out_last    (out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload();
        rf[0] = 8'hAA;
        rf[1] = 8'hF0;
        rf[2] = 8'hCC;
        rf[3] = 8'h33;
        for (int n = 4; n < NR; n++) rf[n] = DW'(n);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_addr"}, out_addr, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_rf_addr"}, rf_addr, 0);
    endtask

    // Observe the DUT mid-cycle; a beat retires when valid and ready both hold.
    task automatic sample();
        beat_t e;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!busy && busy_low < 0 && cyc > 0) busy_low = cyc;
        if (valid) begin
            if (sb.size() == 0) begin
                check("extra_beat_valid", valid, 0);
            end else begin
                e = sb[0];
                check("beat_data", out_data, e.data);
                check("beat_addr", out_addr, e.addr);
                check("beat_last", out_last, e.last);
                check("beat_rf_addr", rf_addr, e.addr);
                if (ready) void'(sb.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_dump(input int stall_at, input int stall_len, input int start_again,
                            input int wr_at, input int abort_at);
        logic [DW-1:0] d;
        logic [DW-1:0] x;
        int            exp_done;
        x = '0;
        for (int a = 0; a < int'(NR); a++) begin
            d = (wr_at >= 0 && a == 10) ? 8'h5A : rf[a];
            x ^= d;
            sb.push_back('{last: (!CsumEn && a == int'(NR) - 1), addr: AW'(a), data: d});
        end
        if (CsumEn) sb.push_back('{last: 1'b1, addr: '0, data: x});
        exp_done = (CsumEn ? 34 : 33) + stall_len;

        done_cnt = 0;
        done_cyc = -1;
        busy_low = -1;
        cyc      = 0;
        ready    = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        while (cyc < 80 && !(done_cnt > 0 && cyc > done_cyc + 1)) begin
            ready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            start = (cyc == start_again);
            if (cyc == wr_at) begin
                rf[10] = 8'h5A;
                rf[1]  = 8'h11;
            end
            if (cyc == abort_at) begin
                check("abort_pre_valid", valid, 1);
                check("abort_pre_addr", out_addr, 5);
                rst_n = 1'b0;
                #1;
                check_quiet("abort");
                sb.delete();
                tick();
                tick();
                check("abort_no_done", done_cnt, 0);
                rst_n = 1'b1;
                return;
            end
            tick();
        end
        start = 1'b0;
        ready = 1'b1;
        check("done_count", done_cnt, 1);
        check("done_cycle", done_cyc, exp_done);
        check("busy_low_cycle", busy_low, exp_done + 1);
        check("beats_left", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        preload();
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full dump, ready held high.
        preload();
        run_dump(-1, 0, -1, -1, -1);
        tick();
        check_quiet("idle_after_dump");

        // Five stall cycles while addr 2 is offered (SEND of byte 2 is cycle 6).
        preload();
        run_dump(6, 5, -1, -1, -1);

        // Start pulse during beat 7 must be ignored.
        preload();
        run_dump(-1, 0, 16, -1, -1);

        // Reset in SEND of addr 5, then a fresh dump from addr 0.
        preload();
        run_dump(-1, 0, -1, -1, 12);
        preload();
        run_dump(-1, 0, -1, -1, -1);

        // Writes to R10 (not yet fetched) and R1 (already fetched) while addr 3 is in SEND.
        preload();
        run_dump(-1, 0, -1, 8, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
